// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared types and constants for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } mdop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    localparam int MDU_MUL_LAT_DEFAULT = 3;
    localparam int MDU_DIV_ITERS       = 32;

    // Two's-complement magnitude of v when en is set, otherwise v unchanged.
    function automatic logic [31:0] f_abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Unsigned restoring divider, one quotient bit per cycle.
//               valid pulses in the cycle after the last iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import mdu_ctrl_pkg::*;
#(
    parameter int ITERS = MDU_DIV_ITERS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        valid
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic        r_run;
    logic        r_valid;

    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic        w_ge;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_trial = {r_rem, r_quo[31]};
    assign w_diff  = w_trial - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[32];

    // Iteration sequencer; quotient bits shift in where dividend bits shift out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (abort) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else if (start) begin
                r_rem <= '0;
                r_quo <= dividend;
                r_dvs <= divisor;
                r_cnt <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_rem <= w_ge ? w_diff[31:0] : w_trial[31:0];
                r_quo <= {r_quo[30:0], w_ge};
                if (r_cnt == 6'(ITERS - 1)) begin
                    r_run   <= 1'b0;
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign valid     = r_valid;

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multiply/divide controller owning architectural HI/LO.
//               MTHI/MTLO in one cycle, MULT/MULTU after MUL_LAT cycles,
//               DIV/DIVU after DIV_ITERS iterations plus a sign-fix cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT   = MDU_MUL_LAT_DEFAULT,
    parameter int DIV_ITERS = MDU_DIV_ITERS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  mdop_t       req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_t  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_is_div;
    logic        w_div_signed;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_valid;
    logic        w_q_neg;
    logic        w_r_neg;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign req_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign w_accept     = req_valid & req_ready & ~flush & (req_op != MD_NONE);
    assign w_is_div     = (req_op == MD_DIV) || (req_op == MD_DIVU);
    assign w_div_signed = (req_op == MD_DIV);

    // Product of the latched operands; low 64 bits of the extended product
    // are exact for both signed and unsigned forms.
    assign w_a64  = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_b64  = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod = w_a64 * w_b64;

    // Divider works on magnitudes; signs are restored in the FIX cycle.
    div_iter #(
        .ITERS     (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (w_accept & w_is_div),
        .abort     (flush & busy),
        .dividend  (f_abs_if(req_a, w_div_signed)),
        .divisor   (f_abs_if(req_b, w_div_signed)),
        .quotient  (w_quo),
        .remainder (w_rem),
        .valid     (w_div_valid)
    );

    assign w_q_neg = r_signed & (r_a[31] ^ r_b[31]);
    assign w_r_neg = r_signed & r_a[31];
    assign w_q_fix = w_q_neg ? (~w_quo + 32'd1) : w_quo;
    assign w_r_fix = w_r_neg ? (~w_rem + 32'd1) : w_rem;

    // Sequencing FSM plus HI/LO ownership; flush beats any pending write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (req_op)
                            MD_MTHI: r_hi <= req_a;
                            MD_MTLO: r_lo <= req_a;
                            MD_MULT, MD_MULTU: begin
                                r_state  <= ST_MUL;
                                r_cnt    <= '0;
                                r_a      <= req_a;
                                r_b      <= req_b;
                                r_signed <= (req_op == MD_MULT);
                            end
                            MD_DIV, MD_DIVU: begin
                                r_state  <= ST_DIV;
                                r_cnt    <= '0;
                                r_a      <= req_a;
                                r_b      <= req_b;
                                r_signed <= (req_op == MD_DIV);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 6'(MUL_LAT - 1)) begin
                        r_hi    <= w_prod[63:32];
                        r_lo    <= w_prod[31:0];
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 6'(DIV_ITERS - 1)) begin
                        r_state <= ST_FIX;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    if (!flush && w_div_valid) begin
                        r_done <= 1'b1;
                        if (r_b == 32'd0) begin
                            // Divide-by-zero: fixed result, no sign fix.
                            r_lo <= 32'hFFFF_FFFF;
                            r_hi <= r_a;
                        end else begin
                            r_lo <= w_q_fix;
                            r_hi <= w_r_fix;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Scoreboard bench for mdu_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    mdop_t       req_op = MD_NONE;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    mdu_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                m_e = sb.pop_front();
                if (hi !== m_e.hi || lo !== m_e.lo || cyc != m_e.cyc) begin
                    bad++;
                    $display("FAIL %s: hi=%h lo=%h cyc=%0d, required hi=%h lo=%h cyc=%0d",
                             m_e.name, hi, lo, cyc, m_e.hi, m_e.lo, m_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Present a request, hold it until accepted, return accept edge index.
    task automatic issue(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input int lat, input string name, output int t);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL %s_ready_timeout: req_ready=0, required 1", name);
        end
        @(posedge clk);
        #1;
        t         = cyc;
        req_valid = 1'b0;
        req_op    = MD_NONE;
        if (push) sb.push_back('{hi: eh, lo: el, cyc: t + lat, name: name});
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // MTHI / MTLO
        issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 0, 0, 0, "mthi", t);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_ready", {31'd0, req_ready}, 32'd1);
        issue(MD_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0, 0, 0, 0, "mtlo", t2);
        chk("mtlo_adjacent", 32'(t2), 32'(t + 1));
        chk("mt_hi", hi, 32'h1234_5678);
        chk("mt_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        // Multiplies
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 3, "mult_neg", t);
        chk("mult_busy", {31'd0, busy}, 32'd1);
        chk("mult_ready", {31'd0, req_ready}, 32'd0);
        chk("mult_hi_stable", hi, 32'h1234_5678);
        wait_idle("mult_idle");
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 3, "multu_max", t);
        wait_idle("multu_idle");

        // Divides
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_neg", t);
        chk("div_ready_start", {31'd0, req_ready}, 32'd0);
        repeat (32) @(posedge clk);
        #1;
        chk("div_ready_last", {31'd0, req_ready}, 32'd0);
        wait_idle("div_idle");
        issue(MD_DIVU, 32'd7, 32'd2, 1'b1, 32'd1, 32'd3, 33, "divu_7_2", t);
        wait_idle("divu_idle");
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 33, "div_pos_neg", t);
        wait_idle("div2_idle");
        issue(MD_DIVU, 32'h55, 32'd0, 1'b1, 32'h55, 32'hFFFF_FFFF, 33, "divu_zero", t);
        wait_idle("divz_idle");
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, "div_zero_signed", t);
        wait_idle("divzs_idle");
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 33, "div_ovf", t);
        wait_idle("divovf_idle");

        // Flush mid-divide, then re-accept
        issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b0, 0, 0, 0, "mthi_a5", t);
        issue(MD_MTLO, 32'hA5A5_A5A5, 32'd0, 1'b0, 0, 0, 0, "mtlo_a5", t);
        issue(MD_DIV, 32'd100, 32'd7, 1'b0, 0, 0, 0, "div_flush", t);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ready", {31'd0, req_ready}, 32'd1);
        chk("flush_hi", hi, 32'hA5A5_A5A5);
        chk("flush_lo", lo, 32'hA5A5_A5A5);
        issue(MD_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 3, "multu_after_flush", t2);
        chk("flush_reaccept", 32'(t2), 32'(t + 11));
        wait_idle("flush_mul_idle");
        repeat (25) @(negedge clk);

        // MTLO held while divide busy
        issue(MD_DIVU, 32'd20, 32'd3, 1'b1, 32'd2, 32'd6, 33, "divu_20_3", t);
        issue(MD_MTLO, 32'h77, 32'd0, 1'b0, 0, 0, 0, "mtlo_wait", t2);
        chk("mtlo_wait_cycle", 32'(t2), 32'(t + 34));
        chk("mtlo_wait_lo", lo, 32'h77);
        chk("mtlo_wait_hi", hi, 32'd2);

        // Flush on the final multiply edge
        issue(MD_MULTU, 32'd5, 32'd5, 1'b0, 0, 0, 0, "mul_flush_last", t);
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_last_lo", lo, 32'h77);
        chk("flush_last_hi", hi, 32'd2);
        chk("flush_last_busy", {31'd0, busy}, 32'd0);

        // Reset during a multiply
        issue(MD_MULT, 32'd3, 32'd4, 1'b0, 0, 0, 0, "mul_reset", t);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("rstmid_hi_late", hi, 32'd0);
        chk("rstmid_lo_late", lo, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
